// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory geometry and the boot-loader
// state encoding. Imported by the loader and by the fetch stage.
package cpu_pkg;

    localparam int unsigned IMEM_ADDR_W = 12;
    localparam int unsigned IMEM_DEPTH  = 4096;

    typedef enum logic [2:0] {
        S_CNT_LO = 3'd0,
        S_CNT_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Takes a byte stream (16-bit LE word count, then that many LE 32-bit words),
// writes each assembled word to instruction memory with a one-cycle strobe,
// and keeps the CPU in reset until the whole program is in place.
// Ports:
//   clk, res          clock (rising edge), async active-low reset
//   byte_valid/data   incoming stream byte, consumed when byte_ready is high
//   byte_ready        loader accepts a byte this cycle
//   reload            pulse; restarts a load once the previous one is done
//   imem_we/addr/wdata  instruction-memory write port
//   cpu_hold          1 = CPU held in reset
//   done              load complete
//   err               header word count too large; sticky until reset
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              res,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = 16;

    loader_state_t    state;
    logic [7:0]       cnt_lo;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_lo;     // lanes 0..2; lane 3 comes straight from the 4th byte
    logic             accept;
    logic [CNT_W-1:0] hdr_count;

    // Ready is purely a decode of the registered state, so no input reaches it.
    assign byte_ready = (state == S_CNT_LO) || (state == S_CNT_HI) || (state == S_DATA);
    assign accept     = byte_valid && byte_ready;
    assign hdr_count  = {byte_data, cnt_lo};

    // Loader FSM with registered outputs.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= S_CNT_LO;
            cnt_lo     <= 8'd0;
            remaining  <= '0;
            byte_idx   <= 2'd0;
            asm_lo     <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                S_CNT_LO: begin
                    if (accept) begin
                        cnt_lo <= byte_data;
                        state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        if (hdr_count == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (hdr_count > CNT_W'(DEPTH)) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            remaining <= hdr_count;
                            imem_addr <= '0;
                            byte_idx  <= 2'd0;
                            state     <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_lo[7:0]   <= byte_data;
                            2'd1: asm_lo[15:8]  <= byte_data;
                            2'd2: asm_lo[23:16] <= byte_data;
                            default: begin
                                // Fourth byte completes the word; strobe next cycle.
                                imem_wdata <= {byte_data, asm_lo};
                                imem_we    <= 1'b1;
                                state      <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DONE: begin
                    if (reload) begin
                        state     <= S_CNT_LO;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        imem_addr <= '0;
                    end
                end
                S_ERR: begin
                    err      <= 1'b1;
                    cpu_hold <= 1'b1;
                    done     <= 1'b0;
                end
                default: begin
                    state <= S_CNT_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams, expected
// writes queued at stimulus time and checked by an independent monitor.
module tb_imem_loader;

    localparam int unsigned AW = 12;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk;
    logic          res;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    imem_loader #(.ADDR_W(AW), .DEPTH(4096)) dut (
        .clk        (clk),
        .res        (res),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (res && imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output int stalls);
        logic rdy;
        stalls = 0;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            stalls++;
            if (stalls > 50) begin
                chk("byte_accept_timeout", 32'(stalls), 32'd0);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_header(input int n);
        int s;
        send_byte(8'(n), 0, s);
        send_byte(8'(n >> 8), 0, s);
    endtask

    // Sends words, expecting them at addresses 0.. in order; counts stall cycles.
    task automatic send_words(input logic [31:0] words[$], input bit rand_gap, output int stalls);
        int s;
        logic [31:0] w;
        stalls = 0;
        foreach (words[i]) begin
            w = words[i];
            exp_q.push_back('{addr: AW'(i), data: w});
            for (int j = 0; j < 4; j++) begin
                send_byte(w[8*j +: 8], rand_gap ? int'($urandom_range(0, 2)) : 0, s);
                stalls += s;
                if (j == 3) begin
                    chk("we_after_4th", 32'(imem_we), 32'd1);
                    chk("ready_in_write", 32'(byte_ready), 32'd0);
                end
            end
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
        chk({tag, "_hold"},  32'(cpu_hold),   32'd1);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
        chk({tag, "_we"},    32'(imem_we),    32'd0);
        chk({tag, "_addr"},  32'(imem_addr),  32'd0);
        chk({tag, "_wdata"}, imem_wdata,      32'd0);
    endtask

    initial begin
        logic [31:0] wq[$];
        int stalls;
        int s;
        int n;

        res = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'd0;
        reload = 1'b0;

        // Asynchronous reset applied mid-cycle, checked before any clock edge.
        #3 res = 1'b0;
        #1 chk_reset_outputs("rst0");
        @(posedge clk);
        #1 res = 1'b1;

        // Two-word program from the example stream.
        send_header(2);
        wq = '{32'h0010_0513, 32'h0020_0593};
        send_words(wq, 1'b0, stalls);
        wait_done(5, "ex_done");
        chk("ex_hold", 32'(cpu_hold), 32'd0);
        chk("ex_ready", 32'(byte_ready), 32'd0);
        chk("ex_addr_end", 32'(imem_addr), 32'd2);

        // Bytes offered while done are ignored.
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("done_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        chk("done_stays", 32'(done), 32'd1);

        // Reload, then a single word.
        pulse_reload();
        chk("rl_hold", 32'(cpu_hold), 32'd1);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_addr", 32'(imem_addr), 32'd0);
        chk("rl_ready", 32'(byte_ready), 32'd1);
        send_header(1);
        wq = '{32'hDEAD_BEEF};
        send_words(wq, 1'b1, stalls);
        wait_done(5, "one_done");
        chk("one_hold", 32'(cpu_hold), 32'd0);

        // Empty program.
        pulse_reload();
        send_header(0);
        wait_done(2, "empty_done");
        chk("empty_hold", 32'(cpu_hold), 32'd0);

        // Continuous valid: exactly one stall per word boundary.
        for (int t = 0; t < 3; t++) begin
            pulse_reload();
            n = int'($urandom_range(1, 8));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom());
            send_header(n);
            send_words(wq, 1'b0, stalls);
            chk("cont_stalls", 32'(stalls), 32'(n - 1));
            wait_done(5, "cont_done");
            chk("cont_addr_end", 32'(imem_addr), 32'(n));
        end

        // Random gaps between bytes.
        for (int t = 0; t < 4; t++) begin
            pulse_reload();
            n = int'($urandom_range(1, 20));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom());
            send_header(n);
            send_words(wq, 1'b1, stalls);
            wait_done(5, "rand_done");
        end

        // Reload while loading is ignored.
        pulse_reload();
        send_header(2);
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        chk("reload_mid_ready", 32'(byte_ready), 32'd1);
        wq = '{32'h1234_5678, 32'h9ABC_DEF0};
        send_words(wq, 1'b0, stalls);
        wait_done(5, "reload_mid_done");

        // Largest legal program: DEPTH words, address wraps to 0 afterwards.
        pulse_reload();
        wq.delete();
        for (int i = 0; i < 4096; i++) wq.push_back($urandom());
        send_header(4096);
        send_words(wq, 1'b0, stalls);
        chk("max_stalls", 32'(stalls), 32'd4095);
        wait_done(5, "max_done");
        chk("max_err", 32'(err), 32'd0);
        chk("max_addr_wrap", 32'(imem_addr), 32'd0);

        // Count one over DEPTH: error, sticky across reload.
        pulse_reload();
        send_byte(8'h01, 0, s);
        send_byte(8'h10, 0, s);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_hold", 32'(cpu_hold), 32'd1);
        chk("ovf_ready", 32'(byte_ready), 32'd0);
        chk("ovf_done", 32'(done), 32'd0);
        pulse_reload();
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_sticky_err", 32'(err), 32'd1);
        chk("ovf_sticky_ready", 32'(byte_ready), 32'd0);

        // Reset leaves the error state.
        #2 res = 1'b0;
        #1 chk_reset_outputs("rst_err");
        @(posedge clk);
        #1 res = 1'b1;

        // Reset mid-load discards the partial word.
        send_header(3);
        wq = '{32'hCAFE_F00D};
        send_words(wq, 1'b0, stalls);
        send_byte(8'h11, 1, s);
        send_byte(8'h22, 0, s);
        #2 res = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        @(posedge clk);
        #1 res = 1'b1;
        send_header(1);
        wq = '{32'h0BAD_C0DE};
        send_words(wq, 1'b1, stalls);
        wait_done(5, "post_rst_done");

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
